// File: rtl/regfile_mp_if.sv
// Register-file bus: two write ports, NRD read ports, busy scoreboard.
// Ports: write ports 0/1, packed read address/data vectors, per-port busy,
//        busy_set request, registered busy_vec and wcollide.
interface regfile_mp_if #(
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned ADDR_W = 2,
   parameter int unsigned NRD    = 2
);
   localparam int unsigned DEPTH = 2**ADDR_W;

   logic                    we0;
   logic [ADDR_W-1:0]       waddr0;
   logic [WIDTH-1:0]        wdata0;
   logic                    we1;
   logic [ADDR_W-1:0]       waddr1;
   logic [WIDTH-1:0]        wdata1;
   logic [NRD*ADDR_W-1:0]   raddr;
   logic [NRD*WIDTH-1:0]    rdata;
   logic [NRD-1:0]          rbusy;
   logic                    busy_set;
   logic [ADDR_W-1:0]       busy_addr;
   logic [DEPTH-1:0]        busy_vec;
   logic                    wcollide;

   // Decode/writeback side drives requests and observes results.
   modport master (
      output we0, waddr0, wdata0, we1, waddr1, wdata1, raddr, busy_set, busy_addr,
      input  rdata, rbusy, busy_vec, wcollide
   );

   // Register file side.
   modport slave (
      input  we0, waddr0, wdata0, we1, waddr1, wdata1, raddr, busy_set, busy_addr,
      output rdata, rbusy, busy_vec, wcollide
   );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port register file with write-through bypass and busy scoreboard.
// Ports: clk, rst (sync, active-high), bus (regfile_mp_if.slave).
//   rdata/rbusy are combinational; busy_vec/wcollide are registered.
module regfile_mp #(
   parameter int unsigned WIDTH    = 8,
   parameter int unsigned ADDR_W   = 2,
   parameter int unsigned NRD      = 2,
   parameter bit          ZERO_REG = 1'b0
) (
   input  logic         clk,
   input  logic         rst,
   regfile_mp_if.slave  bus
);
   localparam int unsigned DEPTH = 2**ADDR_W;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [DEPTH-1:0] busy_q, busy_d;
   logic             wcollide_q, wcollide_d;

   // Writes/busy requests to a hardwired-zero register are dropped up front.
   logic we0_eff, we1_eff, bset_eff;
   assign we0_eff  = bus.we0 && !(ZERO_REG && (bus.waddr0 == '0));
   assign we1_eff  = bus.we1 && !(ZERO_REG && (bus.waddr1 == '0));
   assign bset_eff = bus.busy_set && !(ZERO_REG && (bus.busy_addr == '0));

   // Next-state: port 1 applied last so it wins a same-address write;
   // busy set applied after the completion clear so a re-issue wins.
   always_comb begin
      mem_d      = mem_q;
      busy_d     = busy_q;
      wcollide_d = we0_eff && we1_eff && (bus.waddr0 == bus.waddr1);
      if (we0_eff) mem_d[bus.waddr0] = bus.wdata0;
      if (we1_eff) begin
         mem_d[bus.waddr1]  = bus.wdata1;
         busy_d[bus.waddr1] = 1'b0;
      end
      if (bset_eff) busy_d[bus.busy_addr] = 1'b1;
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         mem_q      <= '{default: '0};
         busy_q     <= '0;
         wcollide_q <= 1'b0;
      end else begin
         mem_q      <= mem_d;
         busy_q     <= busy_d;
         wcollide_q <= wcollide_d;
      end
   end

   assign bus.busy_vec = busy_q;
   assign bus.wcollide = wcollide_q;

   // Read ports: completion write forwarded first, then ALU write, then storage.
   for (genvar i = 0; i < NRD; i++) begin : g_rd
      logic [ADDR_W-1:0] a;
      logic              a_zero, hit0, hit1;
      assign a      = bus.raddr[i*ADDR_W +: ADDR_W];
      assign a_zero = ZERO_REG && (a == '0);
      assign hit1   = we1_eff && (bus.waddr1 == a);
      assign hit0   = we0_eff && (bus.waddr0 == a);
      assign bus.rdata[i*WIDTH +: WIDTH] = (rst || a_zero) ? '0 :
                                           hit1 ? bus.wdata1 :
                                           hit0 ? bus.wdata0 : mem_q[a];
      assign bus.rbusy[i] = !rst && !a_zero && busy_q[a] && !hit1;
   end
endmodule
